// File: rtl/gps_wb_pkg.sv
// Shared constants for the GPS channel Wishbone register bank:
// word offsets of each register, STATUS bit positions and data width.
package gps_wb_pkg;

  localparam int WB_DW  = 32;
  localparam int N_CTRL = 6;
  localparam int N_ACC  = 6;

  // Word offsets (byte offset >> 2)
  localparam logic [5:0] REG_CODE_FREQ = 6'h00;
  localparam logic [5:0] REG_CARR_FREQ = 6'h01;
  localparam logic [5:0] REG_CODE_OFF  = 6'h02;
  localparam logic [5:0] REG_CARR_OFF  = 6'h03;
  localparam logic [5:0] REG_ACQ_THR   = 6'h04;
  localparam logic [5:0] REG_CFG       = 6'h05;
  localparam logic [5:0] REG_P_I       = 6'h06;
  localparam logic [5:0] REG_P_Q       = 6'h07;
  localparam logic [5:0] REG_L_I       = 6'h08;
  localparam logic [5:0] REG_L_Q       = 6'h09;
  localparam logic [5:0] REG_E_I       = 6'h0A;
  localparam logic [5:0] REG_E_Q       = 6'h0B;
  localparam logic [5:0] REG_STATUS    = 6'h0C;

  localparam int ST_READY   = 0;
  localparam int ST_OVERRUN = 1;

endpackage

// File: rtl/gps_acc_snapshot.sv
// Snapshot of the six correlator accumulators plus the DUMP_READY /
// OVERRUN handshake that lets software drain each dump exactly once.
module gps_acc_snapshot
  import gps_wb_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              dump,
  input  logic [N_ACC-1:0][WB_DW-1:0]       acc,
  input  logic                              clr_ready,
  input  logic                              clr_overrun,
  output logic [N_ACC-1:0][WB_DW-1:0]       snap,
  output logic                              ready,
  output logic                              overrun
);

  // A dump is taken when the previous one has been drained, or is being
  // drained on this very edge (the dump wins over the clear).
  logic latch;
  logic collide;

  assign latch   = dump & (~ready | clr_ready);
  assign collide = dump & ready;

  // Snapshot registers and status flags; setting always beats clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap    <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (latch)
        snap <= acc;
      if (dump)
        ready <= 1'b1;
      else if (clr_ready)
        ready <= 1'b0;
      if (collide & ~clr_ready)
        overrun <= 1'b1;
      else if (clr_overrun & ~collide)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/gps_ch_wb_slave.sv
// Wishbone B3 classic slave register bank for one GPS tracking channel:
// control words, accumulator snapshots and dump status.
//
// Handshake: a transfer is accepted ("hit") when cyc & stb & address
// match & ~ack; ack is raised for exactly one cycle on the next edge, with
// read data registered alongside it and write data committed on that same
// edge. Dropping cyc/stb while ack is pending is harmless.
module gps_ch_wb_slave
  import gps_wb_pkg::*;
#(
  parameter int               AW        = 32,
  parameter int               DW        = 32,
  parameter logic [AW-1:0]    BASE_ADDR = 32'h0000_0A00
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  input  logic            dump_i,
  input  logic [31:0]     acc_ip_i,
  input  logic [31:0]     acc_qp_i,
  input  logic [31:0]     acc_il_i,
  input  logic [31:0]     acc_ql_i,
  input  logic [31:0]     acc_ie_i,
  input  logic [31:0]     acc_qe_i,
  output logic [31:0]     code_freq_o,
  output logic [31:0]     carr_freq_o,
  output logic [31:0]     code_off_o,
  output logic [31:0]     carr_off_o,
  output logic [31:0]     acq_thresh_o,
  output logic [31:0]     cfg_o,
  output logic            irq_o
);

  logic                        match;
  logic                        hit;
  logic                        wr_hit;
  logic                        rd_hit;
  logic [5:0]                  word;
  logic [5:0]                  snap_idx;
  logic [N_CTRL-1:0][DW-1:0]   ctrl;
  logic [N_ACC-1:0][DW-1:0]    acc_vec;
  logic [N_ACC-1:0][DW-1:0]    snap;
  logic                        ready;
  logic                        overrun;
  logic                        clr_ready;
  logic                        clr_overrun;
  logic [DW-1:0]               rd_data;
  logic                        unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  assign match    = (wb_adr_i[AW-1:8] == BASE_ADDR[AW-1:8]);
  assign hit      = wb_cyc_i & wb_stb_i & match & ~wb_ack_o;
  assign wr_hit   = hit & wb_we_i;
  assign rd_hit   = hit & ~wb_we_i;
  assign word     = wb_adr_i[7:2];
  assign snap_idx = word - REG_P_I;

  assign acc_vec = {acc_qe_i, acc_ie_i, acc_ql_i, acc_il_i, acc_qp_i, acc_ip_i};

  // STATUS is write-0-to-clear on READY, write-1-to-clear on OVERRUN.
  assign clr_ready   = wr_hit & (word == REG_STATUS) & wb_sel_i[0] & ~wb_dat_i[ST_READY];
  assign clr_overrun = wr_hit & (word == REG_STATUS) & wb_sel_i[0] &  wb_dat_i[ST_OVERRUN];

  gps_acc_snapshot u_snapshot (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .dump        (dump_i),
    .acc         (acc_vec),
    .clr_ready   (clr_ready),
    .clr_overrun (clr_overrun),
    .snap        (snap),
    .ready       (ready),
    .overrun     (overrun)
  );

  // Control words with per-byte write enables.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl <= '0;
    end else begin
      for (int r = 0; r < N_CTRL; r++) begin
        if (wr_hit && word == 6'(r)) begin
          for (int b = 0; b < DW/8; b++) begin
            if (wb_sel_i[b])
              ctrl[r][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read mux samples the registers as they stand before this edge.
  always_comb begin
    rd_data = '0;
    if (word < REG_P_I)
      rd_data = ctrl[word[2:0]];
    else if (word < REG_STATUS)
      rd_data = snap[snap_idx[2:0]];
    else if (word == REG_STATUS)
      rd_data = {{(DW-2){1'b0}}, overrun, ready};
  end

  // Single-cycle ack with registered read data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= hit;
      wb_dat_o <= rd_hit ? rd_data : '0;
    end
  end

  // Interrupt follows DUMP_READY one cycle later.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      irq_o <= 1'b0;
    else
      irq_o <= ready;
  end

  assign code_freq_o  = ctrl[REG_CODE_FREQ[2:0]];
  assign carr_freq_o  = ctrl[REG_CARR_FREQ[2:0]];
  assign code_off_o   = ctrl[REG_CODE_OFF[2:0]];
  assign carr_off_o   = ctrl[REG_CARR_OFF[2:0]];
  assign acq_thresh_o = ctrl[REG_ACQ_THR[2:0]];
  assign cfg_o        = ctrl[REG_CFG[2:0]];

endmodule

// File: tb/tb_gps_ch_wb_slave.sv
// Self-checking bench for gps_ch_wb_slave: directed scenarios plus
// randomized bus traffic and dumps against a register-map model.
module tb_gps_ch_wb_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic [31:0] dat_r;
  logic        ack;
  logic        dump = 1'b0;
  logic [31:0] acc [6];
  logic [31:0] code_freq, carr_freq, code_off, carr_off, acq_thresh, cfg;
  logic        irq;

  // Reference model: register map contents and status flags
  logic [31:0] m_ctrl [6];
  logic [31:0] m_snap [6];
  bit          m_ready;
  bit          m_ovr;
  logic        irq_exp;
  logic        prev_ack;

  // {is_read, data} per acknowledged transfer
  logic [32:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  gps_ch_wb_slave dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc),
    .wb_dat_o(dat_r), .wb_ack_o(ack), .dump_i(dump),
    .acc_ip_i(acc[0]), .acc_qp_i(acc[1]), .acc_il_i(acc[2]),
    .acc_ql_i(acc[3]), .acc_ie_i(acc[4]), .acc_qe_i(acc[5]),
    .code_freq_o(code_freq), .carr_freq_o(carr_freq), .code_off_o(code_off),
    .carr_off_o(carr_off), .acq_thresh_o(acq_thresh), .cfg_o(cfg), .irq_o(irq)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [31:0] model_read(input logic [5:0] w);
    if (w < 6)        return m_ctrl[w];
    else if (w < 12)  return m_snap[w - 6];
    else if (w == 12) return {30'b0, m_ovr, m_ready};
    else              return 32'h0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) begin
      m_ctrl[i] = '0;
      m_snap[i] = '0;
    end
    m_ready = 0;
    m_ovr   = 0;
  endfunction

  // One clock edge worth of effect: optional accepted write, optional dump
  function automatic void model_apply(input bit wr, input logic [5:0] w,
                                      input logic [31:0] d, input logic [3:0] s,
                                      input bit dmp);
    bit clr_r, clr_o;
    clr_r = wr && w == 12 && s[0] && !d[0];
    clr_o = wr && w == 12 && s[0] && d[1];
    if (wr && w < 6)
      for (int b = 0; b < 4; b++)
        if (s[b]) m_ctrl[w][b*8 +: 8] = d[b*8 +: 8];
    if (dmp) begin
      if (m_ready && !clr_r) begin
        m_ovr = 1;
      end else begin
        for (int i = 0; i < 6; i++) m_snap[i] = acc[i];
        if (!m_ready && clr_o) m_ovr = 0;
        m_ready = 1;
      end
    end else begin
      if (clr_r) m_ready = 0;
      if (clr_o) m_ovr = 0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ctrl();
    check("code_freq_o",  code_freq,  m_ctrl[0]);
    check("carr_freq_o",  carr_freq,  m_ctrl[1]);
    check("code_off_o",   code_off,   m_ctrl[2]);
    check("carr_off_o",   carr_off,   m_ctrl[3]);
    check("acq_thresh_o", acq_thresh, m_ctrl[4]);
    check("cfg_o",        cfg,        m_ctrl[5]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic randomize_acc();
    for (int i = 0; i < 6; i++) acc[i] = $urandom();
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit w, input bit with_dump);
    bit match, got;
    match = (a[31:8] == 24'h00000A);
    @(posedge clk); #1;
    adr = a; dat_w = d; sel = s; we = w; cyc = 1; stb = 1;
    if (with_dump) dump = 1;
    if (match) exp_q.push_back({~w, model_read(a[7:2])});
    @(posedge clk); #1;
    model_apply(match && w, a[7:2], d, s, with_dump);
    dump = 0;
    got = 0;
    for (int i = 0; i < 3; i++) begin
      if (ack) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    cyc = 0; stb = 0; we = 0;
    check("ack_presence", {31'b0, got}, {31'b0, match});
    if (match && !got && exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  task automatic pulse_dump();
    @(posedge clk); #1;
    dump = 1;
    @(posedge clk); #1;
    model_apply(0, 6'h0, 32'h0, 4'h0, 1);
    dump = 0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) irq_exp <= 1'b0;
    else     irq_exp <= m_ready;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_ack = 0;
    end else begin
      check("irq_o", {31'b0, irq}, {31'b0, irq_exp});
      if (ack) begin
        check("ack_single_cycle", {31'b0, prev_ack}, 32'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'h1, 32'h0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if (e[32]) check("read_data", dat_r, e[31:0]);
        end
      end
      prev_ack = ack;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 6; i++) acc[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", {31'b0, ack}, 32'h0);
    check("reset dat_o", dat_r, 32'h0);
    check("reset irq", {31'b0, irq}, 32'h0);
    check_ctrl();
    rst = 0;
    for (int w = 0; w < 13; w++) xfer(32'hA00 + w*4, 32'h0, 4'h0, 0, 0);

    // Control word write / readback
    xfer(32'hA00, 32'h16EA4A8C, 4'hF, 1, 0);
    check("code_freq direct", code_freq, 32'h16EA4A8C);
    xfer(32'hA00, 32'h0, 4'h0, 0, 0);
    xfer(32'hA10, 32'hFFFFFFFF, 4'b0010, 1, 0);
    check("acq_thresh byte lane", acq_thresh, 32'h0000FF00);
    xfer(32'hA10, 32'h0, 4'h0, 0, 0);
    xfer(32'hA18, 32'hFFFFFFFF, 4'hF, 1, 0);
    xfer(32'hA18, 32'h0, 4'h0, 0, 0);
    check_ctrl();

    // Dump / overrun handshake
    randomize_acc();
    acc[0] = 32'h12345678;
    pulse_dump();
    @(posedge clk); #1;
    check("irq after dump", {31'b0, irq}, 32'h1);
    xfer(32'hA30, 32'h0, 4'h0, 0, 0);
    xfer(32'hA18, 32'h0, 4'h0, 0, 0);
    randomize_acc();
    acc[0] = 32'hDEAD0000;
    pulse_dump();
    xfer(32'hA18, 32'h0, 4'h0, 0, 0);
    xfer(32'hA30, 32'h0, 4'h0, 0, 0);
    xfer(32'hA30, 32'h2, 4'h1, 1, 0);
    xfer(32'hA30, 32'h0, 4'h0, 0, 0);
    randomize_acc();
    xfer(32'hA30, 32'h0, 4'h1, 1, 1);
    xfer(32'hA30, 32'h0, 4'h0, 0, 0);
    xfer(32'hA1C, 32'h0, 4'h0, 0, 0);
    // READY already set: clear coincident with dump still takes new data
    randomize_acc();
    xfer(32'hA30, 32'h0, 4'h1, 1, 1);
    xfer(32'hA18, 32'h0, 4'h0, 0, 0);
    xfer(32'hA30, 32'h0, 4'h0, 0, 0);
    // Overrun set beats overrun clear
    randomize_acc();
    xfer(32'hA30, 32'h3, 4'h1, 1, 1);
    xfer(32'hA30, 32'h0, 4'h0, 0, 0);
    // Snapshot read in the dump cycle returns the old value
    xfer(32'hA30, 32'h2, 4'h1, 1, 0);
    randomize_acc();
    xfer(32'hA20, 32'h0, 4'h0, 0, 1);
    xfer(32'hA20, 32'h0, 4'h0, 0, 0);

    // Address decode edges
    xfer(32'hC00, 32'h0, 4'h0, 0, 0);
    xfer(32'hC00, 32'hFFFFFFFF, 4'hF, 1, 0);
    xfer(32'hA40, 32'h0, 4'h0, 0, 0);
    xfer(32'hA40, 32'hFFFFFFFF, 4'hF, 1, 0);
    check_ctrl();

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      randomize_acc();
      if (kind < 2) begin
        pulse_dump();
      end else begin
        logic [31:0] a;
        a = ($urandom_range(0, 9) == 0) ? 32'hC00 : 32'hA00;
        a = a + ($urandom_range(0, 20) * 4);
        xfer(a, $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 7) == 0);
      end
      if (n % 25 == 0) check_ctrl();
    end
    check_ctrl();

    // Reset in the middle of a read
    xfer(32'hA04, 32'hCAFEF00D, 4'hF, 1, 0);
    @(posedge clk); #1;
    adr = 32'hA04; we = 0; cyc = 1; stb = 1;
    exp_q.push_back({1'b1, model_read(6'h01)});
    @(posedge clk); #1;
    check("ack before reset", {31'b0, ack}, 32'h1);
    rst = 1;
    #1;
    exp_q.delete();
    model_reset();
    check("ack at reset", {31'b0, ack}, 32'h0);
    check("dat_o at reset", dat_r, 32'h0);
    check_ctrl();
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    rst = 0;

    // Reset before a write commits
    @(posedge clk); #1;
    adr = 32'hA14; dat_w = 32'h5A5A5A5A; sel = 4'hF; we = 1; cyc = 1; stb = 1;
    #2 rst = 1;
    #2 cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    rst = 0;
    check_ctrl();
    xfer(32'hA14, 32'h0, 4'h0, 0, 0);
    xfer(32'hA30, 32'h0, 4'h0, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    check("queue drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
